// File: rtl/instruction_memory_loader.sv
// Streams a length-prefixed byte image into instruction memory as big-endian
// 32-bit words, holding the CPU fetch stage stalled for the whole session.
module instruction_memory_loader #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [1:0] {IDLE, HEADER, LOAD, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           partial_p0;
  logic                  active;
  logic                  xfer;
  logic                  word_fire;

  // Header byte to index of the final word: 0 or anything past DEPTH means a full load.
  function automatic logic [ADDR_WIDTH-1:0] sat_last_idx(input logic [7:0] hdr);
    int n;
    n = int'(hdr);
    if ((n == 0) || (n > DEPTH)) n = DEPTH;
    return ADDR_WIDTH'(n - 1);
  endfunction

  assign active    = (state == HEADER) || (state == LOAD);
  assign xfer      = byte_valid && byte_ready;
  assign word_fire = (state == LOAD) && xfer && (byte_idx == 2'd3) && !abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER: begin
        if (abort)     state_nxt = IDLE;
        else if (xfer) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort)                                  state_nxt = IDLE;
        else if (word_fire && (word_idx == last_idx)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hold stays up through the error pulse so the CPU never restarts mid-abort.
  always_comb begin
    byte_ready = active;
    load_done  = (state == DONE);
    cpu_hold   = (state != IDLE) || load_error;
  end

  // Stage p0: byte assembly and indices; stage p1: registered memory write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_idx   <= '0;
      last_idx   <= '0;
      byte_idx   <= '0;
      partial_p0 <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      load_error <= 1'b0;
    end else begin
      mem_we     <= word_fire;
      load_error <= active && abort;
      if (word_fire) begin
        mem_addr <= word_idx;
        mem_data <= {partial_p0, byte_data};
      end
      case (state)
        IDLE: begin
          if (start) begin
            word_idx   <= '0;
            byte_idx   <= '0;
            partial_p0 <= '0;
          end
        end
        HEADER: begin
          if (!abort && xfer) begin
            last_idx <= sat_last_idx(byte_data);
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        LOAD: begin
          if (!abort && xfer) begin
            if (byte_idx == 2'd3) begin
              byte_idx <= '0;
              if (word_idx != last_idx) word_idx <= word_idx + ADDR_WIDTH'(1);
            end else begin
              byte_idx   <= byte_idx + 2'd1;
              partial_p0 <= {partial_p0[15:0], byte_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: cycle table for the basic and abort
// sequences, then randomized sessions scored against a word-level image model.
module tb_instruction_memory_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, abort, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, mem_we, cpu_hold, load_done, load_error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;

  instruction_memory_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Observed memory image and write log, captured away from the active edge.
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         wr_q[$];
  wr_t         mon_w;
  logic [31:0] act_mem   [DEPTH];
  logic [31:0] model_mem [DEPTH];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      act_mem[mem_addr] = mem_data;
      mon_w.addr = int'(mem_addr);
      mon_w.data = mem_data;
      wr_q.push_back(mon_w);
    end
    if (load_done === 1'b1)  done_cnt++;
    if (load_error === 1'b1) err_cnt++;
  end

  typedef struct {
    logic st, ab, bv; logic [7:0] bd;
    logic rdy, we; logic [AW-1:0] addr; logic [31:0] data;
    logic hold, done, err;
  } vec_t;
  vec_t vecs[24];

  function automatic int model_words(input int hdr);
    return ((hdr == 0) || (hdr > DEPTH)) ? DEPTH : hdr;
  endfunction

  // One load session; abort_at / rst_at are data-byte positions (-1 = unused).
  task automatic run_session(input int hdr, input int abort_at, input int rst_at, input int gap);
    logic [7:0] stream[$];
    int n, len, pos, nw, cyc, mism, exp_done, exp_err;
    logic acc, ab, bv, stopped, hold_ok;
    n = model_words(hdr);
    stream.push_back(8'(hdr));
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
    len = stream.size();
    wr_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    pos = 0; cyc = 0; stopped = 1'b0; hold_ok = 1'b1;
    while (pos < len && !stopped) begin
      if (cyc++ > 4000) begin
        check("session_timeout", 32'd1, 32'd0);
        break;
      end
      if (rst_at >= 0 && pos == 1 + rst_at) begin
        byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_ctrl", {27'd0, byte_ready, mem_we, cpu_hold, load_done, load_error}, 32'd0);
        check("rst_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_data", mem_data, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        stopped = 1'b1;
      end else begin
        ab = (abort_at >= 0) && (pos == 1 + abort_at);
        bv = ab || ($urandom_range(0, 99) >= gap);
        byte_valid = bv;
        byte_data  = stream[pos];
        abort      = ab;
        start      = ($urandom_range(0, 9) == 0);
        acc        = bv && byte_ready;
        if (cpu_hold !== 1'b1) hold_ok = 1'b0;
        @(posedge clock); #1;
        if (ab) stopped = 1'b1;
        if (acc) pos++;
      end
    end
    byte_valid = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    if (rst_at >= 0)        begin nw = rst_at / 4;   exp_done = 0; exp_err = 0; end
    else if (abort_at >= 0) begin nw = abort_at / 4; exp_done = 0; exp_err = 1; end
    else                    begin nw = n;            exp_done = 1; exp_err = 0; end
    check("hold_during", {31'd0, hold_ok}, 32'd1);
    check("wr_count", wr_q.size(), nw);
    for (int i = 0; i < nw; i++) begin
      model_mem[i] = {stream[1+4*i], stream[2+4*i], stream[3+4*i], stream[4+4*i]};
      if (i < wr_q.size()) begin
        check($sformatf("wr_addr%0d", i), wr_q[i].addr, i);
        check($sformatf("wr_data%0d", i), wr_q[i].data, model_mem[i]);
      end
    end
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (act_mem[i] !== model_mem[i]) mism++;
    check("mem_image", mism, 0);
    check("done_cnt", done_cnt, exp_done);
    check("err_cnt", err_cnt, exp_err);
    check("idle_hold", {31'd0, cpu_hold}, 32'd0);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hdr, n, ab_at;
    for (int i = 0; i < DEPTH; i++) begin
      act_mem[i]   = 32'd0;
      model_mem[i] = 32'd0;
    end
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    //          st ab bv bd     rdy we addr data          hold done err
    vecs[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[2]  = '{0, 0, 1, 8'h8C, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[3]  = '{1, 0, 1, 8'h01, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[4]  = '{0, 0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[5]  = '{0, 0, 1, 8'h04, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[6]  = '{0, 0, 1, 8'h20, 1, 1, 0, 32'h8C010004, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[8]  = '{0, 0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[9]  = '{0, 0, 1, 8'h05, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[10] = '{0, 0, 0, 8'h00, 0, 1, 1, 32'h20020005, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0};
    vecs[12] = '{1, 1, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0};
    vecs[13] = '{0, 0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[14] = '{0, 0, 1, 8'h11, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[15] = '{0, 0, 1, 8'h22, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[16] = '{0, 0, 1, 8'h33, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[17] = '{0, 0, 1, 8'h44, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[18] = '{0, 0, 1, 8'h55, 1, 1, 0, 32'h11223344, 1, 0, 0};
    vecs[19] = '{0, 0, 1, 8'h66, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[20] = '{0, 1, 1, 8'h77, 1, 0, 0, 32'h0,        1, 0, 0};
    vecs[21] = '{0, 0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 1};
    vecs[22] = '{0, 1, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0};
    vecs[23] = '{0, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0};

    repeat (2) @(posedge clock);
    #1;
    check("reset_ctrl", {27'd0, byte_ready, mem_we, cpu_hold, load_done, load_error}, 32'd0);
    check("reset_addr", {26'd0, mem_addr}, 32'd0);
    check("reset_data", mem_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 24; i++) begin
      check($sformatf("vec%0d_ctrl", i),
            {27'd0, byte_ready, mem_we, cpu_hold, load_done, load_error},
            {27'd0, vecs[i].rdy, vecs[i].we, vecs[i].hold, vecs[i].done, vecs[i].err});
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), {26'd0, mem_addr}, {26'd0, vecs[i].addr});
        check($sformatf("vec%0d_data", i), mem_data, vecs[i].data);
      end
      start = vecs[i].st; abort = vecs[i].ab;
      byte_valid = vecs[i].bv; byte_data = vecs[i].bd;
      @(posedge clock); #1;
    end
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    check("tbl_mem0", act_mem[0], 32'h11223344);
    check("tbl_mem1", act_mem[1], 32'h20020005);
    model_mem[0] = 32'h11223344;
    model_mem[1] = 32'h20020005;

    run_session(0, -1, -1, 0);
    run_session(3, -1, -1, 40);
    run_session(2, 6, -1, 20);
    run_session(3, 7, -1, 20);
    run_session(3, -1, 6, 20);
    run_session(1, -1, -1, 0);
    run_session(200, -1, -1, 10);
    run_session(64, -1, -1, 30);
    for (int k = 0; k < 8; k++) begin
      hdr = $urandom_range(0, 255);
      n = model_words(hdr);
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
      run_session(hdr, ab_at, -1, $urandom_range(0, 50));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
